// File: rtl/tank_direct_ctrl.sv
// ---------------------------------------------------------------------------
// tank_direct_ctrl
//
// Turns decoded keyboard events into per-tank control signals. Each player
// has a key map {LEFT,RIGHT,UP,DOWN,FIRE}. The block tracks which direction
// keys are held and produces, per player, a registered heading, a moving
// flag and a rate-limited one-cycle fire pulse.
//
// Event interface: key_valid is a one-cycle strobe with no back-pressure.
// ascii/press are meaningful only in a cycle where key_valid=1. Every strobe
// is consumed in the cycle it appears, and the effect shows on the outputs
// in the following cycle.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high; overrides key_valid
//   key_valid  event strobe
//   ascii      key code
//   press      1 = make (press or typematic repeat), 0 = break (release)
//   direct     per player p, bits [3p+2:3p]: LEFT=000 RIGHT=001 UP=010 DOWN=011
//   moving     per player: at least one direction key is held
//   fire       per player: one-cycle fire pulse
// ---------------------------------------------------------------------------
module tank_direct_ctrl #(
    parameter int          NUM_PLAYERS   = 2,
    parameter int          FIRE_COOLDOWN = 16,
    parameter bit          CASE_FOLD     = 1'b1,
    parameter logic [39:0] P0_KEYS       = 40'h61_64_77_73_20,
    parameter logic [39:0] P1_KEYS       = 40'h6A_6C_69_6B_68
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [7:0]               ascii,
    input  logic                     press,
    output logic [3*NUM_PLAYERS-1:0] direct,
    output logic [NUM_PLAYERS-1:0]   moving,
    output logic [NUM_PLAYERS-1:0]   fire
);

    localparam int            CW        = $clog2(FIRE_COOLDOWN + 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(FIRE_COOLDOWN);

    // Direction codes double as bit indices into the held mask.
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic {
        FS_READY = 1'b0,
        FS_COOL  = 1'b1
    } fire_state_e;

    // Heading to fall back to when the current heading key is released
    // while others are still held.
    function automatic logic [1:0] prio_dir(input logic [3:0] m);
        if (m[DIR_UP])        return DIR_UP;
        else if (m[DIR_DOWN]) return DIR_DOWN;
        else if (m[DIR_LEFT]) return DIR_LEFT;
        else                  return DIR_RIGHT;
    endfunction

    // Only matters if a map lists one code for two directions; pick one
    // deterministically.
    function automatic logic [1:0] first_dir(input logic [3:0] m);
        if (m[DIR_LEFT])       return DIR_LEFT;
        else if (m[DIR_RIGHT]) return DIR_RIGHT;
        else if (m[DIR_UP])    return DIR_UP;
        else                   return DIR_DOWN;
    endfunction

    // Upper-case letters fold onto lower case so Shift/CapsLock do not
    // disable a player.
    logic [7:0] code;
    always_comb begin
        code = ascii;
        if (CASE_FOLD && (ascii >= 8'h41) && (ascii <= 8'h5A)) begin
            code = ascii | 8'h20;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam logic [39:0] KMAP = (p == 0) ? P0_KEYS : P1_KEYS;

        logic [3:0]    hit;
        logic          fire_make;
        logic [3:0]    held_nxt;
        logic [1:0]    dir_nxt;

        logic [3:0]    held_q;
        logic [1:0]    dir_q;
        logic          mov_q;
        logic          fire_q;
        fire_state_e   st_q;
        logic [CW-1:0] cnt_q;

        always_comb begin
            hit[DIR_LEFT]  = key_valid && (code == KMAP[39:32]);
            hit[DIR_RIGHT] = key_valid && (code == KMAP[31:24]);
            hit[DIR_UP]    = key_valid && (code == KMAP[23:16]);
            hit[DIR_DOWN]  = key_valid && (code == KMAP[15:8]);
            fire_make      = key_valid && press && (code == KMAP[7:0]);

            held_nxt = press ? (held_q | hit) : (held_q & ~hit);

            // Make: last pressed wins. Break of the current heading: fall
            // back by priority if anything is still held, else keep it.
            dir_nxt = dir_q;
            if (|hit) begin
                if (press) begin
                    dir_nxt = first_dir(hit);
                end else if (hit[dir_q] && (|held_nxt)) begin
                    dir_nxt = prio_dir(held_nxt);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                held_q <= 4'b0000;
                dir_q  <= DIR_RIGHT;
                mov_q  <= 1'b0;
                fire_q <= 1'b0;
                st_q   <= FS_READY;
                cnt_q  <= '0;
            end else begin
                held_q <= held_nxt;
                dir_q  <= dir_nxt;
                mov_q  <= |held_nxt;
                fire_q <= 1'b0;
                case (st_q)
                    FS_READY: begin
                        if (fire_make) begin
                            fire_q <= 1'b1;
                            cnt_q  <= COOL_LOAD;
                            st_q   <= FS_COOL;
                        end
                    end
                    FS_COOL: begin
                        // Makes arriving here are dropped, so a held fire
                        // key repeats once every FIRE_COOLDOWN+1 cycles.
                        if (cnt_q <= 1) begin
                            cnt_q <= '0;
                            st_q  <= FS_READY;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        cnt_q <= '0;
                        st_q  <= FS_READY;
                    end
                endcase
            end
        end

        assign direct[3*p +: 3] = {1'b0, dir_q};
        assign moving[p]        = mov_q;
        assign fire[p]          = fire_q;
    end

endmodule
